sdram_init_seq: RTL and testbench

SDRAM_INIT_SEQ -- requirements
Module: sdram_init_seq

---
 rtl/sdram_init_seq.sv | 168 ++++++++++++++++
 tb/tb_sdram_init_seq.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/sdram_init_seq.sv
// SDRAM power-up initialisation sequencer.
// Runs the power-up wait, then PRECHARGE ALL, REF_NUM x AUTO REFRESH and
// LOAD MODE. After that it holds init_done until reset or a soft init_req.
// All SDRAM pins and status flags are registered.
module sdram_init_seq #(
    parameter int          CLK_FREQ_MHZ = 100,
    parameter int          T_POWERUP_US = 200,
    parameter int          T_RP         = 3,
    parameter int          T_RFC        = 7,
    parameter int          T_MRD        = 2,
    parameter int          REF_NUM      = 8,
    parameter logic [12:0] MODE_REG     = 13'h032
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init_req,
    output logic        sdram_cke,
    output logic        sdram_cs_n,
    output logic        sdram_ras_n,
    output logic        sdram_cas_n,
    output logic        sdram_we_n,
    output logic [1:0]  sdram_ba,
    output logic [12:0] sdram_addr,
    output logic        init_done,
    output logic        init_busy
);

    localparam int unsigned PU_CYC = CLK_FREQ_MHZ * T_POWERUP_US;
    localparam int unsigned PU_W   = $clog2(PU_CYC + 1);
    localparam int unsigned CW     = (PU_W > 16) ? PU_W : 16;

    localparam logic [CW-1:0] PU_LAST  = CW'(PU_CYC);
    localparam logic [CW-1:0] RP_LAST  = CW'(T_RP);
    localparam logic [CW-1:0] RFC_LAST = CW'(T_RFC);
    localparam logic [CW-1:0] MRD_LAST = CW'(T_MRD);
    localparam logic [3:0]    REF_LAST = 4'(REF_NUM);

    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_REF = 4'b0001;
    localparam logic [3:0] CMD_LMR = 4'b0000;

    typedef enum logic [2:0] {
        WAIT_PU, PRE, WAIT_RP, REF, WAIT_RFC, LMR, WAIT_MRD, DONE
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [3:0]    ref_cnt, ref_cnt_nxt;
    logic [3:0]    cmd_nxt;
    logic [1:0]    ba_nxt;
    logic [12:0]   addr_nxt;

    // Next state, spacing counter, refresh count, and the command to register.
    // A command state is entered on the edge that issues the command, and
    // the counter is loaded with 1 at that point. The next command goes out
    // on the edge where the counter equals the required spacing. This lets
    // a spacing of 1 skip the wait state completely.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        ref_cnt_nxt = ref_cnt;
        case (state)
            WAIT_PU: begin
                if (cnt == PU_LAST) begin
                    state_nxt   = PRE;
                    cnt_nxt     = CW'(1);
                    ref_cnt_nxt = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            PRE, WAIT_RP: begin
                if (cnt == RP_LAST) begin
                    state_nxt   = REF;
                    cnt_nxt     = CW'(1);
                    ref_cnt_nxt = ref_cnt + 4'd1;
                end else begin
                    state_nxt = WAIT_RP;
                    cnt_nxt   = cnt + CW'(1);
                end
            end
            REF, WAIT_RFC: begin
                if (cnt == RFC_LAST) begin
                    cnt_nxt = CW'(1);
                    if (ref_cnt == REF_LAST) begin
                        state_nxt = LMR;
                    end else begin
                        state_nxt   = REF;
                        ref_cnt_nxt = ref_cnt + 4'd1;
                    end
                end else begin
                    state_nxt = WAIT_RFC;
                    cnt_nxt   = cnt + CW'(1);
                end
            end
            LMR, WAIT_MRD: begin
                if (cnt == MRD_LAST) begin
                    state_nxt = DONE;
                    cnt_nxt   = '0;
                end else begin
                    state_nxt = WAIT_MRD;
                    cnt_nxt   = cnt + CW'(1);
                end
            end
            DONE: begin
                if (init_req) begin
                    state_nxt   = PRE;
                    cnt_nxt     = CW'(1);
                    ref_cnt_nxt = '0;
                end
            end
            default: begin
                state_nxt   = WAIT_PU;
                cnt_nxt     = '0;
                ref_cnt_nxt = '0;
            end
        endcase

        cmd_nxt  = CMD_NOP;
        ba_nxt   = '0;
        addr_nxt = '0;
        case (state_nxt)
            PRE: begin
                cmd_nxt      = CMD_PRE;
                addr_nxt[10] = 1'b1;
            end
            REF: cmd_nxt = CMD_REF;
            LMR: begin
                cmd_nxt  = CMD_LMR;
                addr_nxt = MODE_REG;
            end
            default: ;
        endcase
    end

    // State, counters and all registered outputs; reset forces NOP with CKE low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= WAIT_PU;
            cnt         <= '0;
            ref_cnt     <= '0;
            sdram_cke   <= 1'b0;
            sdram_cs_n  <= CMD_NOP[3];
            sdram_ras_n <= CMD_NOP[2];
            sdram_cas_n <= CMD_NOP[1];
            sdram_we_n  <= CMD_NOP[0];
            sdram_ba    <= '0;
            sdram_addr  <= '0;
            init_done   <= 1'b0;
            init_busy   <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            ref_cnt     <= ref_cnt_nxt;
            sdram_cke   <= 1'b1;
            sdram_cs_n  <= cmd_nxt[3];
            sdram_ras_n <= cmd_nxt[2];
            sdram_cas_n <= cmd_nxt[1];
            sdram_we_n  <= cmd_nxt[0];
            sdram_ba    <= ba_nxt;
            sdram_addr  <= addr_nxt;
            init_done   <= (state_nxt == DONE);
            init_busy   <= (state_nxt != DONE);
        end
    end

endmodule

// File: tb/tb_sdram_init_seq.sv
// Bench for sdram_init_seq: two instances (scaled defaults and all-minimum timing)
// compared every cycle against a timeline model computed from the command offsets.
module tb_sdram_init_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n_a, rst_n_b, req_a, req_b;
    logic cke_a, cs_a, ras_a, cas_a, we_a, done_a, busy_a;
    logic cke_b, cs_b, ras_b, cas_b, we_b, done_b, busy_b;
    logic [1:0]  ba_a, ba_b;
    logic [12:0] addr_a, addr_b;

    sdram_init_seq #(.CLK_FREQ_MHZ(1), .T_POWERUP_US(10)) u_dut_a (
        .clk(clk), .rst_n(rst_n_a), .init_req(req_a),
        .sdram_cke(cke_a), .sdram_cs_n(cs_a), .sdram_ras_n(ras_a),
        .sdram_cas_n(cas_a), .sdram_we_n(we_a), .sdram_ba(ba_a),
        .sdram_addr(addr_a), .init_done(done_a), .init_busy(busy_a)
    );

    sdram_init_seq #(.CLK_FREQ_MHZ(1), .T_POWERUP_US(10), .T_RP(1), .T_RFC(1),
                     .T_MRD(1), .REF_NUM(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n_b), .init_req(req_b),
        .sdram_cke(cke_b), .sdram_cs_n(cs_b), .sdram_ras_n(ras_b),
        .sdram_cas_n(cas_b), .sdram_we_n(we_b), .sdram_ba(ba_b),
        .sdram_addr(addr_b), .init_done(done_b), .init_busy(busy_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // timing parameters of each instance, as seen by the model
    int p_pu[2]   = '{10, 10};
    int p_rp[2]   = '{3, 1};
    int p_rfc[2]  = '{7, 1};
    int p_mrd[2]  = '{2, 1};
    int p_nref[2] = '{8, 1};

    // model state and observed event times (relative to cycle 0)
    int gc = 0;
    int pre_at[2], cyc0[2];
    bit pend[2] = '{1'b1, 1'b1};
    bit done_q[2];
    int ref_seen[2], pre_rel[2], lmr_rel[2], done_rel[2], fall_rel[2];

    always @(posedge clk) gc <= gc + 1;

    // command expected 'rel' cycles after the PRECHARGE of the current sequence
    function automatic logic [3:0] model_cmd(input int d, input int rel);
        if (rel == 0) return 4'b0010;
        for (int i = 0; i < p_nref[d]; i++)
            if (rel == p_rp[d] + i * p_rfc[d]) return 4'b0001;
        if (rel == p_rp[d] + p_nref[d] * p_rfc[d]) return 4'b0000;
        return 4'b0111;
    endfunction

    function automatic int done_off(input int d);
        return p_rp[d] + p_nref[d] * p_rfc[d] + p_mrd[d];
    endfunction

    task automatic mon(input int d, input logic rstn, input logic req, input logic cke,
                       input logic [3:0] cmd, input logic [1:0] ba, input logic [12:0] addr,
                       input logic done, input logic busy);
        string nm;
        int    rel;
        logic [3:0] ecmd;
        logic  edone;
        nm = (d == 0) ? "A" : "B";
        if (!rstn || pend[d]) begin
            check_eq({nm, "_reset_vals"}, {11'd0, cke, cmd, ba, addr, done, busy},
                     {11'd0, 1'b0, 4'b0111, 2'b00, 13'h0, 1'b0, 1'b0});
            done_q[d]   = 1'b0;
            ref_seen[d] = 0;
            pre_rel[d]  = -1;
            lmr_rel[d]  = -1;
            done_rel[d] = -1;
            fall_rel[d] = -1;
            if (!rstn) pend[d] = 1'b1;
            else begin
                pend[d]   = 1'b0;
                cyc0[d]   = gc + 1;
                pre_at[d] = gc + 1 + p_pu[d];
            end
            return;
        end
        rel   = gc - pre_at[d];
        ecmd  = model_cmd(d, rel);
        edone = (rel >= done_off(d));
        check_eq({nm, "_cke"}, cke, 1'b1);
        check_eq({nm, "_cmd"}, cmd, ecmd);
        check_eq({nm, "_done"}, done, edone);
        check_eq({nm, "_busy"}, busy, !edone);
        if (ecmd == 4'b0111) check_eq({nm, "_nop_ba_addr"}, {ba, addr}, 15'h0);
        if (ecmd == 4'b0010) check_eq({nm, "_pre_a10"}, addr[10], 1'b1);
        if (ecmd == 4'b0000) check_eq({nm, "_lmr_ba_addr"}, {ba, addr}, {2'b00, 13'h032});
        if (cmd == 4'b0010) begin pre_rel[d] = gc - cyc0[d]; ref_seen[d] = 0; end
        if (cmd == 4'b0001) ref_seen[d]++;
        if (cmd == 4'b0000) lmr_rel[d] = gc - cyc0[d];
        if (done && !done_q[d]) done_rel[d] = gc - cyc0[d];
        if (!done && done_q[d]) fall_rel[d] = gc - cyc0[d];
        done_q[d] = done;
        if (req && edone) pre_at[d] = gc + 1;
    endtask

    always @(negedge clk) begin
        mon(0, rst_n_a, req_a, cke_a, {cs_a, ras_a, cas_a, we_a}, ba_a, addr_a, done_a, busy_a);
        mon(1, rst_n_b, req_b, cke_b, {cs_b, ras_b, cas_b, we_b}, ba_b, addr_b, done_b, busy_b);
    end

    task automatic go_cyc(input int n);
        repeat (n) @(posedge clk);
        #3;
    endtask

    // advance to just after edge 'c' of instance A's current sequence
    task automatic to_cycle(input int c);
        int n;
        n = c - (gc - cyc0[0]);
        go_cyc(n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rst_at;
        rst_n_a = 1'b0; rst_n_b = 1'b0; req_a = 1'b0; req_b = 1'b0;
        go_cyc(3);
        rst_n_a = 1'b1; rst_n_b = 1'b1;
        go_cyc(1);                                  // now in cycle 0

        // init_req mid-refresh is ignored; timeline unchanged
        to_cycle(40); req_a = 1'b1; go_cyc(1); req_a = 1'b0;
        // init_req one cycle before init_done rises is also ignored
        to_cycle(70); req_a = 1'b1; go_cyc(1); req_a = 1'b0;
        to_cycle(95);
        check_eq("s1_pre",  pre_rel[0], 10);
        check_eq("s1_refs", ref_seen[0], 8);
        check_eq("s1_lmr",  lmr_rel[0], 69);
        check_eq("s1_done", done_rel[0], 71);
        check_eq("min_pre",  pre_rel[1], 10);
        check_eq("min_refs", ref_seen[1], 1);
        check_eq("min_lmr",  lmr_rel[1], 12);
        check_eq("min_done", done_rel[1], 13);

        // soft re-initialisation from DONE
        to_cycle(100); req_a = 1'b1; go_cyc(1); req_a = 1'b0;
        to_cycle(180);
        check_eq("s2_pre",  pre_rel[0], 101);
        check_eq("s2_fall", fall_rel[0], 101);
        check_eq("s2_refs", ref_seen[0], 8);
        check_eq("s2_lmr",  lmr_rel[0], 160);
        check_eq("s2_done", done_rel[0], 162);

        // reset asserted at cycle 30 for 5 cycles
        rst_n_a = 1'b0; go_cyc(2); rst_n_a = 1'b1; go_cyc(1);
        to_cycle(30);
        rst_n_a = 1'b0;
        #1;
        check_eq("async_rst", {cke_a, cs_a, ras_a, cas_a, we_a, done_a, busy_a, ba_a, addr_a},
                 {1'b0, 4'b0111, 1'b0, 1'b0, 2'b00, 13'h0});
        repeat (5) @(posedge clk);
        #3; rst_n_a = 1'b1;
        go_cyc(1);
        to_cycle(90);
        check_eq("s3_pre",  pre_rel[0], 10);
        check_eq("s3_lmr",  lmr_rel[0], 69);
        check_eq("s3_done", done_rel[0], 71);

        // random init_req pulses and occasional mid-sequence resets
        for (int it = 0; it < 6; it++) begin
            rst_n_a = 1'b0; req_a = 1'b0;
            go_cyc($urandom_range(3, 1));
            rst_n_a = 1'b1;
            go_cyc(1);
            rst_at = ($urandom_range(2, 0) == 0) ? int'($urandom_range(150, 5)) : -1;
            for (int c = 1; c <= 200; c++) begin
                if (c == rst_at) begin
                    req_a = 1'b0; rst_n_a = 1'b0;
                    go_cyc($urandom_range(4, 1));
                    rst_n_a = 1'b1;
                end else begin
                    req_a = !req_a && ($urandom_range(11, 0) == 0);
                    go_cyc(1);
                end
            end
            req_a = 1'b0;
        end
        go_cyc(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
